mdp3_encoder: RTL and testbench

//  Turns one book-update record (price, qty, orders, action, entry type) into a 37-byte MDP3 incremental-refresh frame.

---
 rtl/mdp3_encoder_if.sv | 27 ++
 rtl/mdp3_encoder.sv | 144 ++++++++++++++
 tb/tb_mdp3_encoder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdp3_encoder_if.sv
// Update-record input handshake and frame-word output stream of mdp3_encoder.
// The encoder takes the slave view; the upstream/downstream environment takes the master view.
interface mdp3_encoder_if;
   logic        upd_valid;
   logic        upd_ready;
   logic [63:0] SENDING_TIME;
   logic [63:0] PRICE;
   logic [15:0] QUANTITY;
   logic [7:0]  NUM_ORDERS;
   logic [1:0]  ACTION;
   logic [1:0]  ENTRY_TYPE;
   logic [63:0] MESSAGE;
   logic        msg_valid;
   logic        msg_ready;
   logic        msg_last;
   logic [7:0]  msg_keep;

   modport master (
      output upd_valid, SENDING_TIME, PRICE, QUANTITY, NUM_ORDERS, ACTION, ENTRY_TYPE, msg_ready,
      input  upd_ready, MESSAGE, msg_valid, msg_last, msg_keep
   );

   modport slave (
      input  upd_valid, SENDING_TIME, PRICE, QUANTITY, NUM_ORDERS, ACTION, ENTRY_TYPE, msg_ready,
      output upd_ready, MESSAGE, msg_valid, msg_last, msg_keep
   );
endinterface

// File: rtl/mdp3_encoder.sv
// Book-update record -> 37-byte MDP3 incremental-refresh frame as five 64-bit words (byte 0 in [63:56]).
// Latency: word 0 one cycle after capture, then one word per accepted beat; words held while msg_ready is low.
// Backpressure: records taken only in IDLE, or also on word-4 acceptance when MDP3_ENCODER_BACK2BACK_EN is defined.
module mdp3_encoder #(
   parameter logic [31:0] SEQ_INIT    = 32'h0000_0001,
   parameter logic [15:0] TEMPLATE_ID = 16'd46,
   parameter logic [15:0] SCHEMA_ID   = 16'd1,
   parameter logic [15:0] VERSION     = 16'd9
) (
   input  logic          clk,
   input  logic          reset,
   mdp3_encoder_if.slave bus
);
   localparam logic [15:0] MSG_SIZE  = 16'd25;
   localparam logic [15:0] BLOCK_LEN = 16'd15;

   typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, W4} state_t;

   typedef struct packed {
      logic [63:0] sending_time;
      logic [63:0] price;
      logic [15:0] quantity;
      logic [7:0]  num_orders;
      logic [1:0]  action;
      logic [1:0]  entry_type;
   } upd_t;

   state_t       state, state_nxt;
   upd_t         rec, upd_in;
   logic [31:0]  seq;
   logic         armed;
   logic         capture, frame_done;
   logic [319:0] frame;
   logic         upd_ready_c, msg_valid_c, msg_last_c;
   logic [7:0]   msg_keep_c;
   logic [63:0]  message_c;

   function automatic logic [15:0] bswap16(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [63:0] bswap64(input logic [63:0] v);
      return {bswap32(v[31:0]), bswap32(v[63:32])};
   endfunction

   assign upd_in = '{sending_time: bus.SENDING_TIME, price: bus.PRICE, quantity: bus.QUANTITY,
                     num_orders: bus.NUM_ORDERS, action: bus.ACTION, entry_type: bus.ENTRY_TYPE};

   // Whole frame is rebuilt from the captured record; seq only moves once word 4 is gone.
   assign frame = {bswap32(seq), bswap64(rec.sending_time), bswap16(MSG_SIZE), bswap16(BLOCK_LEN),
                   bswap16(TEMPLATE_ID), bswap16(SCHEMA_ID), bswap16(VERSION), bswap64(rec.price),
                   bswap32({16'd0, rec.quantity}), rec.num_orders, {6'd0, rec.action},
                   {6'd0, rec.entry_type}, 24'd0};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // armed keeps upd_ready low while reset is held and for the first cycle after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rec   <= '0;
         seq   <= SEQ_INIT;
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (capture)    rec <= upd_in;
         if (frame_done) seq <= seq + 32'd1;
      end
   end

   always_comb begin
      state_nxt   = state;
      upd_ready_c = 1'b0;
      msg_valid_c = 1'b0;
      msg_last_c  = 1'b0;
      msg_keep_c  = 8'h00;
      message_c   = 64'd0;
      capture     = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            upd_ready_c = armed;
            if (armed && bus.upd_valid) begin
               capture   = 1'b1;
               state_nxt = W0;
            end
         end
         W0: begin
            msg_valid_c = 1'b1;
            msg_keep_c  = 8'hFF;
            message_c   = frame[319:256];
            if (bus.msg_ready) state_nxt = W1;
         end
         W1: begin
            msg_valid_c = 1'b1;
            msg_keep_c  = 8'hFF;
            message_c   = frame[255:192];
            if (bus.msg_ready) state_nxt = W2;
         end
         W2: begin
            msg_valid_c = 1'b1;
            msg_keep_c  = 8'hFF;
            message_c   = frame[191:128];
            if (bus.msg_ready) state_nxt = W3;
         end
         W3: begin
            msg_valid_c = 1'b1;
            msg_keep_c  = 8'hFF;
            message_c   = frame[127:64];
            if (bus.msg_ready) state_nxt = W4;
         end
         W4: begin
            msg_valid_c = 1'b1;
            msg_keep_c  = 8'hF8;
            msg_last_c  = 1'b1;
            message_c   = frame[63:0];
            if (bus.msg_ready) begin
               frame_done = 1'b1;
               state_nxt  = IDLE;
`ifdef MDP3_ENCODER_BACK2BACK_EN
               upd_ready_c = 1'b1;
               if (bus.upd_valid) begin
                  capture   = 1'b1;
                  state_nxt = W0;
               end
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.upd_ready = upd_ready_c;
   assign bus.msg_valid = msg_valid_c;
   assign bus.msg_last  = msg_last_c;
   assign bus.msg_keep  = msg_keep_c;
   assign bus.MESSAGE   = message_c;
endmodule

// File: tb/tb_mdp3_encoder.sv
// Scoreboard bench for mdp3_encoder: two instances (normal and wrapping SEQ_INIT) run in lockstep,
// expected words queued at record acceptance and popped by a monitor on each accepted beat.
module tb_mdp3_encoder;
   typedef struct packed {
      logic [63:0] st;
      logic [63:0] price;
      logic [15:0] qty;
      logic [7:0]  orders;
      logic [1:0]  action;
      logic [1:0]  etype;
   } rec_t;

   typedef struct packed {
      logic [63:0] dat;
      logic        last;
      logic [7:0]  keep;
   } beat_t;

   localparam logic [31:0]  SEQ_A = 32'h021CC2C0;
   localparam logic [31:0]  SEQ_B = 32'hFFFFFFFF;
   localparam logic [255:0] TAIL  = {64'h0000000019000F00, 64'h2E0001000900A047,
                                     64'h5F3B000000000F00, 64'h0000020100000000};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mdp3_encoder_if bus();
   mdp3_encoder_if wbus();

   mdp3_encoder #(.SEQ_INIT(SEQ_A)) dut   (.clk(clk), .reset(reset), .bus(bus.slave));
   mdp3_encoder #(.SEQ_INIT(SEQ_B)) dut_w (.clk(clk), .reset(reset), .bus(wbus.slave));

   assign wbus.upd_valid    = bus.upd_valid;
   assign wbus.SENDING_TIME = bus.SENDING_TIME;
   assign wbus.PRICE        = bus.PRICE;
   assign wbus.QUANTITY     = bus.QUANTITY;
   assign wbus.NUM_ORDERS   = bus.NUM_ORDERS;
   assign wbus.ACTION       = bus.ACTION;
   assign wbus.ENTRY_TYPE   = bus.ENTRY_TYPE;
   assign wbus.msg_ready    = bus.msg_ready;

   beat_t exp_q[$];
   beat_t expw_q[$];
   rec_t  rec_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic [31:0] seq_m, seqw_m;
   int    mode = 0;      // 0: ready high, 1: ready toggles, 2: ready low
   bit    gap_en = 1'b0;
   bit    gap_done = 1'b0;

   task automatic check(input string name, input bit ok, input logic [159:0] act, input logic [159:0] req);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [319:0] model_frame(input logic [31:0] seq, input rec_t r);
      logic [7:0]   b [40];
      logic [319:0] f;
      for (int i = 0; i < 40; i++) b[i] = 8'h00;
      for (int i = 0; i < 4; i++) b[i] = seq[8*i +: 8];
      for (int i = 0; i < 8; i++) b[4+i] = r.st[8*i +: 8];
      b[12] = 8'd25; b[14] = 8'd15; b[16] = 8'd46; b[18] = 8'd1; b[20] = 8'd9;
      for (int i = 0; i < 8; i++) b[22+i] = r.price[8*i +: 8];
      b[30] = r.qty[7:0]; b[31] = r.qty[15:8];
      b[34] = r.orders; b[35] = {6'd0, r.action}; b[36] = {6'd0, r.etype};
      for (int i = 0; i < 40; i++) f[319-8*i -: 8] = b[i];
      return f;
   endfunction

   function automatic rec_t decode(input logic [319:0] f);
      logic [7:0] b [40];
      rec_t r;
      for (int i = 0; i < 40; i++) b[i] = f[319-8*i -: 8];
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r.st[8*i +: 8]    = b[4+i];
         r.price[8*i +: 8] = b[22+i];
      end
      r.qty    = {b[31], b[30]};
      r.orders = b[34];
      r.action = b[35][1:0];
      r.etype  = b[36][1:0];
      return r;
   endfunction

   // lit 1/2: hand-computed words for record r0 as first/second frame after reset.
   task automatic push(input rec_t r, input int lit);
      logic [319:0] f, fw;
      beat_t b;
      case (lit)
         1:       begin f = {64'hC0C21C023D010000, TAIL}; fw = {64'hFFFFFFFF3D010000, TAIL}; end
         2:       begin f = {64'hC1C21C023D010000, TAIL}; fw = {64'h000000003D010000, TAIL}; end
         default: begin f = model_frame(seq_m, r); fw = model_frame(seqw_m, r); end
      endcase
      for (int i = 0; i < 5; i++) begin
         b.last = (i == 4);
         b.keep = (i == 4) ? 8'hF8 : 8'hFF;
         b.dat  = f[319-64*i -: 64];
         exp_q.push_back(b);
         b.dat  = fw[319-64*i -: 64];
         expw_q.push_back(b);
      end
      seq_m  = seq_m + 32'd1;
      seqw_m = seqw_m + 32'd1;
      rec_q.push_back(r);
   endtask

   task automatic scramble_inputs();
      bus.upd_valid    = 1'b0;
      bus.SENDING_TIME = {$urandom, $urandom};
      bus.PRICE        = {$urandom, $urandom};
      bus.QUANTITY     = 16'($urandom);
      bus.NUM_ORDERS   = 8'($urandom);
      bus.ACTION       = 2'($urandom);
      bus.ENTRY_TYPE   = 2'($urandom);
   endtask

   task automatic send(input rec_t r, input int lit);
      int t;
      bus.upd_valid    = 1'b1;
      bus.SENDING_TIME = r.st;
      bus.PRICE        = r.price;
      bus.QUANTITY     = r.qty;
      bus.NUM_ORDERS   = r.orders;
      bus.ACTION       = r.action;
      bus.ENTRY_TYPE   = r.etype;
      t = 0;
      @(negedge clk);
      while (!bus.upd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.upd_ready) check("upd_ready_timeout", 1'b0, 160'(bus.upd_ready), 160'd1);
      else push(r, lit);
      @(posedge clk);
      #1;
      scramble_inputs();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || expw_q.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0 || expw_q.size() != 0)
         check("drain_timeout", 1'b0, 160'(exp_q.size()), 160'd0);
   endtask

   // msg_ready driver: changes 2 time units after the edge, after the stimulus has set mode.
   initial begin : ready_drv
      bus.msg_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (mode)
            0:       bus.msg_ready = 1'b1;
            1:       bus.msg_ready = ~bus.msg_ready;
            default: bus.msg_ready = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      beat_t        e;
      logic [72:0]  held;
      bit           stalled;
      bit           gap_armed;
      int           gap_cnt;
      int           widx;
      logic [319:0] acc;
      rec_t         rr;
      stalled = 1'b0; gap_armed = 1'b0; gap_cnt = 0; widx = 0; acc = '0; held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled = 1'b0;
            widx    = 0;
            continue;
         end
         if (stalled)
            check("hold_while_stalled", {bus.MESSAGE, bus.msg_last, bus.msg_keep} == held,
                  160'({bus.MESSAGE, bus.msg_last, bus.msg_keep}), 160'(held));
         stalled = bus.msg_valid && !bus.msg_ready;
         held    = {bus.MESSAGE, bus.msg_last, bus.msg_keep};
         if (gap_armed) begin
            if (bus.msg_valid) begin
`ifdef MDP3_ENCODER_BACK2BACK_EN
               check("frame_gap", gap_cnt == 0, 160'(gap_cnt), 160'd0);
`else
               check("frame_gap", gap_cnt >= 1, 160'(gap_cnt), 160'd1);
`endif
               gap_armed = 1'b0;
               gap_done  = 1'b1;
            end else begin
               gap_cnt++;
            end
         end
         if (bus.msg_valid && bus.msg_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 1'b0, 160'(bus.MESSAGE), 160'd0);
            end else begin
               e = exp_q.pop_front();
               check("word", {bus.MESSAGE, bus.msg_last, bus.msg_keep} == e,
                     160'({bus.MESSAGE, bus.msg_last, bus.msg_keep}), 160'(e));
            end
            if (widx < 5) acc[319-64*widx -: 64] = bus.MESSAGE;
            widx++;
            if (bus.msg_last) begin
               if (rec_q.size() != 0) begin
                  rr = rec_q.pop_front();
                  check("decoded_fields", decode(acc) == rr, 160'(decode(acc)), 160'(rr));
               end
               widx = 0;
               if (gap_en && !gap_done) begin
                  gap_armed = 1'b1;
                  gap_cnt   = 0;
               end
            end
         end
         if (wbus.msg_valid && wbus.msg_ready) begin
            if (expw_q.size() == 0) begin
               check("unexpected_word_wrap", 1'b0, 160'(wbus.MESSAGE), 160'd0);
            end else begin
               e = expw_q.pop_front();
               check("word_wrap", {wbus.MESSAGE, wbus.msg_last, wbus.msg_keep} == e,
                     160'({wbus.MESSAGE, wbus.msg_last, wbus.msg_keep}), 160'(e));
            end
         end
      end
   end

   initial begin : stim
      rec_t r0, r1, r2, r3;
      r0 = '{st: 64'h13D, price: 64'h3B5F47A0, qty: 16'h000F, orders: 8'h02, action: 2'd1, etype: 2'd0};
      r1 = '{st: 64'hFFFF_FFFF_FFFF_FFFF, price: 64'h8000_0000_0000_0001, qty: 16'hFFFF,
             orders: 8'hFF, action: 2'd3, etype: 2'd3};
      r2 = '{st: 64'h0, price: 64'h0, qty: 16'h0, orders: 8'h0, action: 2'd0, etype: 2'd0};
      r3 = '{st: 64'h0123_4567_89AB_CDEF, price: 64'hFEDC_BA98_7654_3210, qty: 16'h1234,
             orders: 8'h56, action: 2'd2, etype: 2'd1};
      seq_m  = SEQ_A;
      seqw_m = SEQ_B;
      reset  = 1'b1;
      scramble_inputs();
      repeat (2) @(negedge clk);
      check("rst_msg_valid", bus.msg_valid == 1'b0, 160'(bus.msg_valid), 160'd0);
      check("rst_upd_ready", bus.upd_ready == 1'b0, 160'(bus.upd_ready), 160'd0);
      check("rst_msg_last",  bus.msg_last == 1'b0,  160'(bus.msg_last),  160'd0);
      check("rst_msg_keep",  bus.msg_keep == 8'h00, 160'(bus.msg_keep),  160'd0);
      check("rst_message",   bus.MESSAGE == 64'd0,  160'(bus.MESSAGE),   160'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      send(r0, 1);
      drain();

      mode = 1;
      send(r0, 2);
      drain();
      mode = 0;

      gap_en = 1'b1;
      send(r1, 0);
      send(r3, 0);
      drain();

      mode = 2;
      send(r2, 0);
      repeat (6) @(posedge clk);
      #1 mode = 0;
      drain();

      // Abort a frame in W2 (capture edge -> W0, two more edges -> W2).
      send(r3, 0);
      repeat (2) @(posedge clk);
      #1;
      check("w2_valid", bus.msg_valid == 1'b1, 160'(bus.msg_valid), 160'd1);
      reset = 1'b1;
      #1;
      check("abort_msg_valid",      bus.msg_valid == 1'b0,  160'(bus.msg_valid),  160'd0);
      check("abort_msg_valid_wrap", wbus.msg_valid == 1'b0, 160'(wbus.msg_valid), 160'd0);
      exp_q.delete();
      expw_q.delete();
      rec_q.delete();
      seq_m  = SEQ_A;
      seqw_m = SEQ_B;
      @(posedge clk);
      #1 reset = 1'b0;
      send(r0, 1);
      drain();

      mode = 1;
      send(r1, 0);
      send(r2, 0);
      drain();
      mode = 0;
      repeat (3) @(negedge clk);

      check("gap_measured", gap_done == 1'b1, 160'(gap_done), 160'd1);
      check("leftover_records", rec_q.size() == 0, 160'(rec_q.size()), 160'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
